// File: rtl/dot_matrix_scheduler_if.sv
// Write-side handshake for the dot-matrix scheduler: one shadow-buffer row per beat,
// with wr_last committing the frame.
interface dot_matrix_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_last;

  modport master (output wr_valid, output wr_row, output wr_data, output wr_last,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_row, input  wr_data, input  wr_last,
                  output wr_ready);
endinterface

// File: rtl/dot_matrix_scheduler.sv
// 8x8 dot-matrix row scanner with a double-buffered frame: writes land in the shadow
// buffer, and a committed frame is swapped into the display buffer only at the row 7->0 wrap.
module dot_matrix_scheduler #(
  parameter int unsigned SCAN_DIV = 2500
) (
  input  logic                         clk,
  input  logic                         reset,
  dot_matrix_scheduler_if.slave        wr,
  output logic [7:0]                   dot_row,
  output logic [7:0]                   dot_column,
  output logic                         frame_swap
);

  typedef enum logic {ST_OPEN, ST_PENDING} wr_state_e;

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [15:0]     presc_q, presc_d;
  logic [2:0]      row_q, row_d;
  wr_state_e       state_q, state_d;
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [7:0][7:0] display_q, display_d;
  logic [7:0]      dot_row_q, dot_row_d;
  logic [7:0]      dot_col_q, dot_col_d;
  logic            swap_q, swap_d;

  logic            tick;
  logic            wrap_tick;
  logic            accept;
  logic            do_swap;

  function automatic logic [7:0] row_select(input logic [2:0] r);
    return ~(8'h80 >> r);
  endfunction

  assign tick      = (presc_q == PRESC_MAX);
  assign wrap_tick = tick && (row_q == 3'd7);
  assign accept    = (state_q == ST_OPEN) && wr.wr_valid;
  // A commit accepted on the wrap tick itself is still OPEN here, so it waits a full frame.
  assign do_swap   = (state_q == ST_PENDING) && wrap_tick;

  always_comb begin
    presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    row_d     = row_q;
    state_d   = state_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    dot_row_d = dot_row_q;
    dot_col_d = dot_col_q;
    swap_d    = 1'b0;

    if (accept) begin
      shadow_d[wr.wr_row] = wr.wr_data;
    end

    if (do_swap) begin
      display_d = shadow_q;
      swap_d    = 1'b1;
      state_d   = ST_OPEN;
    end else if (accept && wr.wr_last) begin
      state_d = ST_PENDING;
    end

    // Column data comes from display_d so the swapping tick already shows the new row 0.
    if (tick) begin
      row_d     = row_q + 3'd1;
      dot_row_d = row_select(row_d);
      dot_col_d = display_d[row_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= 16'd0;
      row_q     <= 3'd7;
      state_q   <= ST_OPEN;
      shadow_q  <= '0;
      display_q <= '0;
      dot_row_q <= 8'hFF;
      dot_col_q <= 8'h00;
      swap_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      row_q     <= row_d;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      dot_row_q <= dot_row_d;
      dot_col_q <= dot_col_d;
      swap_q    <= swap_d;
    end
  end

  assign wr.wr_ready = (state_q == ST_OPEN);
  assign dot_row     = dot_row_q;
  assign dot_column  = dot_col_q;
  assign frame_swap  = swap_q;

endmodule

// File: tb/tb_dot_matrix_scheduler.sv
// Bench for dot_matrix_scheduler (SCAN_DIV=4): directed scenarios plus random beats, every
// cycle compared against a frame-level reference model driven by cycle-count arithmetic.
module tb_dot_matrix_scheduler;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       reset;
  logic [7:0] dot_row;
  logic [7:0] dot_column;
  logic       frame_swap;

  dot_matrix_scheduler_if wr_if ();

  dot_matrix_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_if),
    .dot_row    (dot_row),
    .dot_column (dot_column),
    .frame_swap (frame_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_shadow [8];
  logic [7:0] m_disp   [8];
  bit         m_pend;
  int         m_cyc;
  logic [7:0] m_row;
  logic [7:0] m_col;
  bit         m_swap;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 8'h00;
      m_disp[i]   = 8'h00;
    end
    m_pend = 0;
    m_cyc  = 0;
    m_row  = 8'hFF;
    m_col  = 8'h00;
    m_swap = 0;
  endtask

  task automatic check_all();
    chk("dot_row",    dot_row,           m_row);
    chk("dot_column", dot_column,        m_col);
    chk("frame_swap", {7'd0, frame_swap}, {7'd0, m_swap});
    chk("wr_ready",   {7'd0, wr_if.wr_ready}, {7'd0, !m_pend});
  endtask

  function automatic bit next_is_wrap();
    int nt;
    nt = (m_cyc + 1) / SCAN_DIV;
    return (((m_cyc + 1) % SCAN_DIV) == 0) && (((nt - 1) % 8) == 0);
  endfunction

  // One clock: drive a beat, advance the model across the edge, compare all outputs.
  task automatic step(input bit v, input logic [2:0] r, input logic [7:0] d, input bit l);
    bit tk, wrp, acc, sw;
    int nt, rr;
    wr_if.wr_valid = v;
    wr_if.wr_row   = r;
    wr_if.wr_data  = d;
    wr_if.wr_last  = l;
    acc = v && !m_pend;
    tk  = ((m_cyc + 1) % SCAN_DIV) == 0;
    nt  = (m_cyc + 1) / SCAN_DIV;
    rr  = tk ? ((nt - 1) % 8) : 0;
    wrp = tk && (rr == 0);
    sw  = m_pend && wrp;
    @(posedge clk);
    m_cyc++;
    if (acc) m_shadow[r] = d;
    if (sw) for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
    if (tk) begin
      m_row = ~(8'h80 >> rr);
      m_col = m_disp[rr];
    end
    m_swap = sw;
    if (sw) m_pend = 0;
    else if (acc && l) m_pend = 1;
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic wait_swap(input string tag);
    int n = 0;
    while (!frame_swap && n < 80) begin
      idle();
      n++;
    end
    chk(tag, {7'd0, frame_swap}, 8'd1);
  endtask

  task automatic wait_row(input logic [7:0] target, input string tag);
    int n = 0;
    while (dot_row !== target && n < 40) begin
      idle();
      n++;
    end
    chk(tag, dot_row, target);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    model_clear();
    #1;
    chk("rst_dot_row",    dot_row,    8'hFF);
    chk("rst_dot_column", dot_column, 8'h00);
    chk("rst_frame_swap", {7'd0, frame_swap}, 8'd0);
    chk("rst_wr_ready",   {7'd0, wr_if.wr_ready}, 8'd1);
    repeat (2) @(posedge clk);
    #3;
    check_all();
    reset = 1'b1;
  endtask

  logic [7:0] frame_a [8];
  int         swaps;

  initial begin
    frame_a = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};
    reset = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_row   = 3'd0;
    wr_if.wr_data  = 8'h00;
    wr_if.wr_last  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    // Idle scan: first tick after SCAN_DIV cycles selects row 0, then rows walk 1..7, 0.
    repeat (SCAN_DIV - 1) idle();
    chk("pre_first_tick", dot_row, 8'hFF);
    idle();
    chk("first_tick_row0", dot_row, 8'h7F);
    repeat (4 * SCAN_DIV) idle();
    chk("row4_after_4_ticks", dot_row, 8'hF7);
    repeat (4 * SCAN_DIV) idle();
    chk("row0_after_wrap", dot_row, 8'h7F);
    chk("idle_column", dot_column, 8'h00);

    // Full frame load with commit on row 7.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), frame_a[i], i == 7);
    chk("pending_ready_low", {7'd0, wr_if.wr_ready}, 8'd0);
    wait_swap("swap_full_frame");
    chk("swap_row0_sel", dot_row, 8'h7F);
    chk("swap_row0_col", dot_column, 8'h18);
    wait_row(8'hFE, "reach_row7");
    chk("row7_col", dot_column, 8'h7E);

    // Writes while PENDING are ignored.
    step(1'b1, 3'd0, 8'h18, 1'b1);
    swaps = 0;
    for (int n = 0; n < 80 && swaps == 0; n++) begin
      step(1'b1, 3'd3, 8'hFF, 1'b0);
      if (frame_swap) swaps++;
    end
    chk("pending_commit_swapped", 8'(swaps), 8'd1);
    wr_if.wr_valid = 1'b0;
    wait_row(8'hEF, "reach_row3");
    chk("row3_unchanged", dot_column, 8'hC3);

    // Partial rewrite merges with the persisting shadow.
    step(1'b1, 3'd2, 8'hFF, 1'b1);
    wait_swap("swap_partial");
    wait_row(8'hDF, "reach_row2");
    chk("row2_rewritten", dot_column, 8'hFF);
    wait_row(8'hFB, "reach_row5");
    chk("row5_kept", dot_column, 8'h42);

    // Commit accepted exactly on a wrap tick waits a full frame.
    begin
      int n = 0;
      while (!next_is_wrap() && n < 40) begin
        idle();
        n++;
      end
      step(1'b1, 3'd6, 8'h42, 1'b1);
      chk("no_swap_on_commit_wrap", {7'd0, frame_swap}, 8'd0);
      n = 0;
      while (!frame_swap && n < 80) begin
        idle();
        n++;
      end
      chk("commit_to_swap_cycles", 8'(n), 8'd32);
    end

    // Reset while PENDING in the middle of row 4 discards the commit.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'h5A ^ 8'(i), i == 7);
    wait_row(8'hF7, "reach_row4_pending");
    idle();
    apply_reset();
    swaps = 0;
    for (int n = 0; n < 40; n++) begin
      idle();
      if (frame_swap) swaps++;
      if (dot_column !== 8'h00) swaps += 100;
    end
    chk("post_reset_blank_no_swap", 8'(swaps), 8'd0);

    // Random beats against the reference model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
